// File: rtl/cnn_train_sequencer_if.sv
// Sequencer <-> CNN link: image/label/start toward the CNN, done/prediction back.
//   input_image  : IMG_DIM x IMG_DIM packed signed Q8.8 pixels, [row][col]
//   label        : signed Q8.8 target
//   start        : CNN start request
//   done         : CNN done (level)
//   output_value : signed Q8.8 CNN prediction
interface cnn_train_sequencer_if #(
    parameter int unsigned IMG_DIM = 4,
    parameter int unsigned DATA_W  = 16
);
    logic [IMG_DIM-1:0][IMG_DIM-1:0][DATA_W-1:0] input_image;
    logic signed [DATA_W-1:0]                    label;
    logic                                        start;
    logic                                        done;
    logic signed [DATA_W-1:0]                    output_value;

    modport master (
        output input_image, label, start,
        input  done, output_value
    );

    modport slave (
        input  input_image, label, start,
        output done, output_value
    );
endinterface

// File: rtl/cnn_train_sequencer.sv
// Replays a small labelled training set through a CNN for NUM_EPOCHS epochs,
// reporting per-sample signed/absolute error and a per-epoch absolute-error loss.
//   clk, rst             : clock, async active-high reset
//   wr_*                 : dataset write port (honoured only when idle/finished)
//   run, abort           : start a run / abandon it
//   cnn                  : CNN link (image, label, start, done, output_value)
//   busy, finished       : run status
//   result_*             : one-cycle per-sample result pulse and payload
//   epoch_valid/_loss    : one-cycle end-of-epoch pulse and epoch loss
module cnn_train_sequencer #(
    parameter int unsigned NUM_SAMPLES  = 2,
    parameter int unsigned NUM_EPOCHS   = 20,
    parameter int unsigned IMG_DIM      = 4,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned START_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic                          wr_is_label,
    input  logic [$clog2(NUM_SAMPLES):0]  wr_sample,
    input  logic [$clog2(IMG_DIM):0]      wr_row,
    input  logic [$clog2(IMG_DIM):0]      wr_col,
    input  logic signed [DATA_W-1:0]      wr_data,
    input  logic                          run,
    input  logic                          abort,
    cnn_train_sequencer_if.master         cnn,
    output logic                          busy,
    output logic                          finished,
    output logic                          result_valid,
    output logic [15:0]                   result_epoch,
    output logic [$clog2(NUM_SAMPLES):0]  result_sample,
    output logic signed [DATA_W-1:0]      result_error,
    output logic signed [DATA_W-1:0]      result_abs_error,
    output logic                          epoch_valid,
    output logic [31:0]                   epoch_loss
);
    localparam int unsigned SW  = $clog2(NUM_SAMPLES) + 1;
    localparam int unsigned PW  = $clog2(IMG_DIM) + 1;
    localparam int unsigned SIW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int unsigned IIW = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
    localparam int unsigned CW  = $clog2(START_CYCLES + 1);
    localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef logic [IMG_DIM-1:0][IMG_DIM-1:0][DATA_W-1:0] image_t;
    typedef enum logic [2:0] {
        IDLE, SETUP, START, WAIT_DONE, REPORT, EPOCH_END, FINISHED
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         epoch_q, epoch_d;
    logic [SW-1:0]       sample_q, sample_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                done_q;
    logic [31:0]         loss_q, loss_d;
    image_t              image_q, image_d;
    logic [DATA_W-1:0]   label_q, label_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic                finished_q, finished_d;
    logic                rvalid_q, rvalid_d;
    logic [15:0]         repoch_q, repoch_d;
    logic [SW-1:0]       rsample_q, rsample_d;
    logic [DATA_W-1:0]   rerr_q, rerr_d;
    logic [DATA_W-1:0]   rabs_q, rabs_d;
    logic                evalid_q, evalid_d;
    logic [31:0]         eloss_q, eloss_d;

    image_t              ds_pix [NUM_SAMPLES];
    logic [DATA_W-1:0]   ds_lbl [NUM_SAMPLES];

    logic                idle_c, wr_ok_c, done_rise_c;
    logic signed [DATA_W:0] diff_c;
    logic [DATA_W-1:0]   err_c, abs_c;
    logic [32:0]         sum_c;
    logic [31:0]         loss_sat_c;

    assign idle_c      = (state_q == IDLE) || (state_q == FINISHED);
    assign done_rise_c = cnn.done && !done_q;
    // A run on the same edge wins over the write.
    assign wr_ok_c     = wr_en && idle_c && !run && (wr_sample < SW'(NUM_SAMPLES));

    // Dataset storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok_c && wr_is_label) begin
            ds_lbl[SIW'(wr_sample)] <= wr_data;
        end
        if (wr_ok_c && !wr_is_label && (wr_row < PW'(IMG_DIM)) && (wr_col < PW'(IMG_DIM))) begin
            ds_pix[SIW'(wr_sample)][IIW'(wr_row)][IIW'(wr_col)] <= wr_data;
        end
    end

    // Saturated prediction error and its magnitude.
    always_comb begin
        diff_c = {cnn.output_value[DATA_W-1], cnn.output_value} - {label_q[DATA_W-1], label_q};
        if (diff_c[DATA_W] != diff_c[DATA_W-1]) begin
            err_c = diff_c[DATA_W] ? S_MIN : S_MAX;
        end else begin
            err_c = diff_c[DATA_W-1:0];
        end
        if (err_c == S_MIN) begin
            abs_c = S_MAX;
        end else if (err_c[DATA_W-1]) begin
            abs_c = DATA_W'(-err_c);
        end else begin
            abs_c = err_c;
        end
    end

    // Loss accumulation including the current result, saturating at 2^32-1.
    always_comb begin
        sum_c      = {1'b0, loss_q} + 33'(rabs_q);
        loss_sat_c = sum_c[32] ? '1 : sum_c[31:0];
    end

    // State register and all output/datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            epoch_q    <= '0;
            sample_q   <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            loss_q     <= '0;
            image_q    <= '0;
            label_q    <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            rvalid_q   <= 1'b0;
            repoch_q   <= '0;
            rsample_q  <= '0;
            rerr_q     <= '0;
            rabs_q     <= '0;
            evalid_q   <= 1'b0;
            eloss_q    <= '0;
        end else begin
            state_q    <= state_d;
            epoch_q    <= epoch_d;
            sample_q   <= sample_d;
            cnt_q      <= cnt_d;
            done_q     <= cnn.done;
            loss_q     <= loss_d;
            image_q    <= image_d;
            label_q    <= label_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
            rvalid_q   <= rvalid_d;
            repoch_q   <= repoch_d;
            rsample_q  <= rsample_d;
            rerr_q     <= rerr_d;
            rabs_q     <= rabs_d;
            evalid_q   <= evalid_d;
            eloss_q    <= eloss_d;
        end
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FINISHED: if (run) state_d = SETUP;
            SETUP:          state_d = START;
            START:          if (cnt_q == CW'(START_CYCLES - 1)) state_d = WAIT_DONE;
            WAIT_DONE:      if (done_rise_c) state_d = REPORT;
            REPORT:         state_d = (sample_q < SW'(NUM_SAMPLES - 1)) ? SETUP : EPOCH_END;
            EPOCH_END:      state_d = (epoch_q < 16'(NUM_EPOCHS - 1)) ? SETUP : FINISHED;
            default:        state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // Counters, captures and registered outputs, keyed on the state being entered.
    always_comb begin
        epoch_d    = epoch_q;
        sample_d   = sample_q;
        loss_d     = loss_q;
        image_d    = image_q;
        label_d    = label_q;
        repoch_d   = repoch_q;
        rsample_d  = rsample_q;
        rerr_d     = rerr_q;
        rabs_d     = rabs_q;
        eloss_d    = eloss_q;
        cnt_d      = (state_q == START) ? cnt_q + CW'(1) : '0;
        start_d    = (state_d == START);
        busy_d     = (state_d != IDLE) && (state_d != FINISHED);
        finished_d = (state_d == FINISHED);
        rvalid_d   = (state_d == REPORT);
        evalid_d   = (state_d == EPOCH_END);

        if (idle_c && state_d == SETUP) begin
            epoch_d  = '0;
            sample_d = '0;
            loss_d   = '0;
        end
        if (state_q == SETUP) begin
            image_d = ds_pix[SIW'(sample_q)];
            label_d = ds_lbl[SIW'(sample_q)];
        end
        if (state_d == REPORT) begin
            repoch_d  = epoch_q;
            rsample_d = sample_q;
            rerr_d    = err_c;
            rabs_d    = abs_c;
        end
        if (state_q == REPORT) begin
            loss_d = loss_sat_c;
            if (state_d == SETUP) sample_d = sample_q + SW'(1);
        end
        if (state_d == EPOCH_END) begin
            eloss_d = loss_sat_c;
        end
        if (state_q == EPOCH_END) begin
            loss_d = '0;
            if (state_d == SETUP) begin
                epoch_d  = epoch_q + 16'd1;
                sample_d = '0;
            end
        end
    end

    assign cnn.input_image  = image_q;
    assign cnn.label        = label_q;
    assign cnn.start        = start_q;
    assign busy             = busy_q;
    assign finished         = finished_q;
    assign result_valid     = rvalid_q;
    assign result_epoch     = repoch_q;
    assign result_sample    = rsample_q;
    assign result_error     = rerr_q;
    assign result_abs_error = rabs_q;
    assign epoch_valid      = evalid_q;
    assign epoch_loss       = eloss_q;
endmodule

// File: tb/tb_cnn_train_sequencer.sv
// Directed self-checking bench for cnn_train_sequencer with a small CNN stub.
module tb_cnn_train_sequencer;
    localparam int NS = 2;
    localparam int NE = 3;
    localparam int ID = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0, wr_is_label = 1'b0, run = 1'b0, abort = 1'b0;
    logic [1:0] wr_sample = '0;
    logic [2:0] wr_row = '0, wr_col = '0;
    logic signed [DW-1:0] wr_data = '0;
    logic busy, finished, result_valid, epoch_valid;
    logic [15:0] result_epoch;
    logic [1:0] result_sample;
    logic signed [DW-1:0] result_error, result_abs_error;
    logic [31:0] epoch_loss;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cnn_train_sequencer_if #(.IMG_DIM(ID), .DATA_W(DW)) cnn ();

    cnn_train_sequencer #(
        .NUM_SAMPLES(NS), .NUM_EPOCHS(NE), .IMG_DIM(ID), .DATA_W(DW), .START_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_is_label(wr_is_label), .wr_sample(wr_sample),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .run(run), .abort(abort), .cnn(cnn),
        .busy(busy), .finished(finished),
        .result_valid(result_valid), .result_epoch(result_epoch),
        .result_sample(result_sample), .result_error(result_error),
        .result_abs_error(result_abs_error),
        .epoch_valid(epoch_valid), .epoch_loss(epoch_loss)
    );

    // CNN stub: auto mode answers 5 cycles after start drops, choosing the answer by label.
    logic manual = 1'b0;
    logic man_done = 1'b0;
    logic signed [DW-1:0] man_ov = '0;
    logic signed [DW-1:0] lab0 = '0, ans0 = '0, ans1 = '0;
    logic auto_done = 1'b0, armed = 1'b0, start_prev = 1'b0;
    logic signed [DW-1:0] auto_ov = '0;
    int wcnt = 0;

    always @(posedge clk) begin
        start_prev <= cnn.start;
        if (cnn.start && !start_prev) begin
            auto_done <= 1'b0;
            armed     <= 1'b1;
            wcnt      <= 0;
            auto_ov   <= (cnn.label == lab0) ? ans0 : ans1;
        end else if (armed && !cnn.start) begin
            if (wcnt == 4) begin
                auto_done <= 1'b1;
                armed     <= 1'b0;
            end
            wcnt <= wcnt + 1;
        end
    end

    assign cnn.done         = manual ? man_done : auto_done;
    assign cnn.output_value = manual ? man_ov : auto_ov;

    task automatic load_sample(input int s, input logic signed [DW-1:0] pix,
                               input logic signed [DW-1:0] lab);
        for (int r = 0; r < ID; r++) begin
            for (int c = 0; c < ID; c++) begin
                @(negedge clk);
                wr_en = 1'b1; wr_is_label = 1'b0;
                wr_sample = 2'(s); wr_row = 3'(r); wr_col = 3'(c); wr_data = pix;
            end
        end
        @(negedge clk);
        wr_is_label = 1'b1; wr_data = lab;
        @(negedge clk);
        wr_en = 1'b0; wr_is_label = 1'b0;
    endtask

    task automatic pulse_run();
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || finished !== 1'b0 || cnn.start !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%b finished=%b start=%b, required 0/0/0", busy, finished, cnn.start);
        end
        checks++;
        if (result_valid !== 1'b0 || epoch_valid !== 1'b0 || epoch_loss !== 32'd0 || result_error !== 16'sd0) begin
            errors++;
            $display("FAIL reset_results: rv=%b ev=%b loss=%0d err=%0d, required 0", result_valid, epoch_valid, epoch_loss, result_error);
        end
        checks++;
        if (cnn.label !== 16'sd0 || cnn.input_image !== '0) begin
            errors++;
            $display("FAIL reset_image: label=%0d, required 0 with zero image", cnn.label);
        end
    endtask

    // Full run of NE epochs; checks every result and epoch pulse against expectations.
    task automatic test_training(input string name,
                                 input logic signed [DW-1:0] l0, input logic signed [DW-1:0] l1,
                                 input logic signed [DW-1:0] p0, input logic signed [DW-1:0] p1,
                                 input logic signed [DW-1:0] e0, input logic signed [DW-1:0] e1,
                                 input logic signed [DW-1:0] a0, input logic signed [DW-1:0] a1,
                                 input logic [31:0] exp_loss);
        int nres = 0;
        int nep = 0;
        bit fin = 0;
        int s;
        manual = 1'b0;
        lab0 = l0;
        pulse_run();
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            if (result_valid) begin
                s = nres % 2;
                checks++;
                if (result_epoch !== 16'(nres / 2) || result_sample !== 2'(s)) begin
                    errors++;
                    $display("FAIL %s_index: epoch=%0d sample=%0d, required %0d/%0d", name, result_epoch, result_sample, nres / 2, s);
                end
                checks++;
                if (result_error !== (s == 0 ? e0 : e1) || result_abs_error !== (s == 0 ? a0 : a1)) begin
                    errors++;
                    $display("FAIL %s_error: err=%0d abs=%0d, required %0d/%0d", name, result_error, result_abs_error,
                             s == 0 ? e0 : e1, s == 0 ? a0 : a1);
                end
                checks++;
                if (cnn.label !== (s == 0 ? l0 : l1) || cnn.input_image[3][3] !== (s == 0 ? p0 : p1)) begin
                    errors++;
                    $display("FAIL %s_image: label=%0d pix=%0d, required %0d/%0d", name, cnn.label,
                             $signed(cnn.input_image[3][3]), s == 0 ? l0 : l1, s == 0 ? p0 : p1);
                end
                nres++;
            end
            if (epoch_valid) begin
                checks++;
                if (epoch_loss !== exp_loss) begin
                    errors++;
                    $display("FAIL %s_loss: epoch_loss=%0d, required %0d", name, epoch_loss, exp_loss);
                end
                nep++;
            end
            if (finished) fin = 1;
        end
        checks++;
        if (!fin || nres != NS * NE || nep != NE) begin
            errors++;
            $display("FAIL %s_count: finished=%0d results=%0d epochs=%0d, required 1/%0d/%0d", name, fin, nres, nep, NS * NE, NE);
        end
        checks++;
        if (busy !== 1'b0 || cnn.start !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: busy=%b start=%b, required 0/0", name, busy, cnn.start);
        end
    endtask

    task automatic test_abort_idle();
        pulse_abort();
        checks++;
        if (finished !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: finished=%b busy=%b, required 0/0", finished, busy);
        end
    endtask

    // done held high: not accepted until it falls and rises; start lasts exactly 2 cycles.
    task automatic test_done_held();
        int nst = 0;
        bit early = 0;
        manual = 1'b1; man_done = 1'b1; man_ov = 16'sd0;
        pulse_run();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cnn.start) nst++;
            if (result_valid) early = 1;
        end
        checks++;
        if (nst != 2) begin
            errors++;
            $display("FAIL start_width_s0: start cycles=%0d, required 2", nst);
        end
        checks++;
        if (early || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_held: early_result=%0d busy=%b, required 0/1", early, busy);
        end
        man_done = 1'b0;
        @(negedge clk); man_done = 1'b1;
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b1 || result_error !== 16'sd32767 || result_sample !== 2'd0) begin
            errors++;
            $display("FAIL done_rise: rv=%b err=%0d sample=%0d, required 1/32767/0", result_valid, result_error, result_sample);
        end
        nst = 0; early = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cnn.start) nst++;
            if (result_valid) early = 1;
        end
        checks++;
        if (nst != 2 || early) begin
            errors++;
            $display("FAIL start_width_s1: start cycles=%0d early_result=%0d, required 2/0", nst, early);
        end
        pulse_abort();
        manual = 1'b0;
    endtask

    // Abort in WAIT_DONE of epoch 1 sample 1, then a clean restart.
    task automatic test_abort_run();
        bit found = 0;
        bit got = 0;
        bit pulse = 0;
        manual = 1'b0; lab0 = 16'sd256; ans0 = 16'sd300; ans1 = -16'sd20;
        pulse_run();
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (result_valid && result_epoch == 16'd1 && result_sample == 2'd0) found = 1;
        end
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (cnn.start) found = 1;
        end
        for (int i = 0; i < 50 && found; i++) begin
            @(negedge clk);
            if (!cnn.start) found = 0;
        end
        checks++;
        if (found || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: reached_wait=%0d busy=%b, required 1/1", !found, busy);
        end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || cnn.start !== 1'b0 || finished !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b start=%b fin=%b rv=%b, required 0", busy, cnn.start, finished, result_valid);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (result_valid || epoch_valid || busy) pulse = 1;
        end
        checks++;
        if (pulse) begin
            errors++;
            $display("FAIL abort_quiet: activity after abort=%0d, required 0", pulse);
        end
        pulse_run();
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (result_valid) got = 1;
        end
        checks++;
        if (!got || result_epoch !== 16'd0 || result_sample !== 2'd0 || result_error !== 16'sd44) begin
            errors++;
            $display("FAIL restart_result: got=%0d epoch=%0d sample=%0d err=%0d, required 1/0/0/44", got, result_epoch, result_sample, result_error);
        end
        got = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (epoch_valid) got = 1;
        end
        checks++;
        if (!got || epoch_loss !== 32'd64) begin
            errors++;
            $display("FAIL restart_loss: got=%0d loss=%0d, required 1/64", got, epoch_loss);
        end
        pulse_abort();
    endtask

    // Writes during a run are dropped; async reset in START drops start/busy at once.
    task automatic test_wr_busy_and_rst();
        bit found = 0;
        load_sample(0, 16'sd123, 16'sd256);
        pulse_run();
        @(negedge clk);
        wr_en = 1'b1; wr_is_label = 1'b0; wr_sample = 2'd0; wr_row = 3'd1; wr_col = 3'd2; wr_data = 16'sh7777;
        @(negedge clk);
        wr_is_label = 1'b1; wr_data = 16'sd999;
        @(negedge clk);
        wr_en = 1'b0; wr_is_label = 1'b0;
        pulse_abort();
        pulse_run();
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (cnn.start) found = 1;
        end
        checks++;
        if (!found || $signed(cnn.input_image[1][2]) !== 16'sd123 || cnn.label !== 16'sd256) begin
            errors++;
            $display("FAIL wr_while_busy: start=%0d pix=%0d label=%0d, required 1/123/256", found,
                     $signed(cnn.input_image[1][2]), cnn.label);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cnn.start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: start=%b busy=%b, required 0/0", cnn.start, busy);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cnn.start !== 1'b0 || finished !== 1'b0) begin
            errors++;
            $display("FAIL post_rst: busy=%b start=%b fin=%b, required 0", busy, cnn.start, finished);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();

        load_sample(0, 16'sd256, 16'sd256);
        load_sample(1, 16'sd0, 16'sd0);
        ans0 = 16'sd256; ans1 = 16'sd0;
        test_training("zero_err", 16'sd256, 16'sd0, 16'sd256, 16'sd0,
                      16'sd0, 16'sd0, 16'sd0, 16'sd0, 32'd0);
        test_abort_idle();

        ans0 = 16'sd300; ans1 = -16'sd20;
        test_training("signed_err", 16'sd256, 16'sd0, 16'sd256, 16'sd0,
                      16'sd44, -16'sd20, 16'sd44, 16'sd20, 32'd64);

        load_sample(0, 16'sd100, -16'sd32768);
        load_sample(1, -16'sd100, 16'sd32767);
        ans0 = 16'sd32767; ans1 = -16'sd32768;
        test_training("saturate", -16'sd32768, 16'sd32767, 16'sd100, -16'sd100,
                      16'sd32767, -16'sd32768, 16'sd32767, 16'sd32767, 32'd65534);

        test_done_held();

        load_sample(0, 16'sd256, 16'sd256);
        load_sample(1, 16'sd0, 16'sd0);
        test_abort_run();

        test_wr_busy_and_rst();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
